// File: rtl/spi_master_px.sv
// Full-duplex SPI master on the Hack I/O bus: configurable frame width, runtime
// clock divider, CPOL/CPHA modes, multiple active-low chip selects, done/overrun flags.
module spi_master_px #(
    parameter int WIDTH    = 8,
    parameter int NCS      = 1,
    parameter int DIV_INIT = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           addr,
    input  logic [15:0]    in,
    output logic [15:0]    out,
    output logic [NCS-1:0] CSX,
    output logic           SDO,
    input  logic           SDI,
    output logic           SCK
);
    localparam logic [5:0] LAST_TICK = 6'(2 * WIDTH + 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t           state;
    logic [WIDTH-1:0] shift;
    logic             done;
    logic             ovr;
    logic             cpha;
    logic             cpol;
    logic             cs_en;
    logic [2:0]       cs_sel;
    logic [7:0]       div;
    logic [7:0]       cnt;
    logic [5:0]       tick;
    logic [5:0]       tick_nx;
    logic             samp;
    logic             sck_q;
    logic             sdi_p0;
    logic             sdi_p1;
    logic             busy;
    logic             sample_now;
    logic             shift_now;
    logic [15:0]      data_rd;
    logic             unused_in;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s, input logic b);
        logic [WIDTH:0] t;
        t = {s, b};
        return t[WIDTH-1:0];
    endfunction

    assign busy      = (state == XFER);
    assign tick_nx   = tick + 6'd1;
    assign unused_in = ^{in[3], in[7]};

    // CPHA=0 samples on odd ticks and shifts on even ones; CPHA=1 the other way round.
    assign sample_now = cpha ? ~tick_nx[0] : (tick_nx[0] && (tick_nx != LAST_TICK));
    assign shift_now  = cpha ? (tick_nx[0] && (tick_nx != 6'd1)) : ~tick_nx[0];

    // SDI is asynchronous to clk: two-flop synchroniser
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sdi_p0 <= 1'b0;
            sdi_p1 <= 1'b0;
        end else begin
            sdi_p0 <= SDI;
            sdi_p1 <= sdi_p0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            shift  <= '0;
            done   <= 1'b0;
            ovr    <= 1'b0;
            cpha   <= 1'b0;
            cpol   <= 1'b0;
            cs_en  <= 1'b0;
            cs_sel <= 3'd0;
            div    <= 8'(DIV_INIT);
            cnt    <= 8'd0;
            tick   <= 6'd0;
            samp   <= 1'b0;
            sck_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load && addr) begin
                        cpha   <= in[0];
                        cpol   <= in[1];
                        cs_en  <= in[2];
                        cs_sel <= in[6:4];
                        div    <= in[15:8];
                        ovr    <= 1'b0;
                        sck_q  <= in[1];
                    end else if (load) begin
                        shift <= in[WIDTH-1:0];
                        done  <= 1'b0;
                        cnt   <= 8'd0;
                        tick  <= 6'd0;
                        state <= XFER;
                    end
                end
                XFER: begin
                    // writes during a frame are dropped and only flagged
                    if (load) ovr <= 1'b1;
                    if (cnt == div) begin
                        cnt  <= 8'd0;
                        tick <= tick_nx;
                        if (tick_nx != LAST_TICK) sck_q <= ~sck_q;
                        if (sample_now) samp <= sdi_p1;
                        if (shift_now) shift <= shift_in(shift, samp);
                        if (tick_nx == LAST_TICK) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        CSX = '1;
        for (int i = 0; i < NCS; i++) begin
            if (cs_en && (cs_sel == 3'(i))) CSX[i] = 1'b0;
        end
    end

    always_comb begin
        data_rd              = '0;
        data_rd[WIDTH-1:0]   = shift;
        if (addr) out = {busy, done, ovr, 6'd0, cs_sel, 1'b0, cs_en, cpol, cpha};
        else      out = data_rd;
    end

    assign SDO = shift[WIDTH-1];
    assign SCK = sck_q;

endmodule

// File: tb/tb_spi_master_px.sv
// Directed bench for spi_master_px: an 8-bit/4-CS instance and a 16-bit/1-CS
// instance, driven from a vector table plus hand-written corner sequences.
module tb_spi_master_px;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_a = 1'b0;
    logic        load_b = 1'b0;
    logic        addr = 1'b0;
    logic        SDI = 1'b0;
    logic [15:0] in = 16'd0;
    logic [15:0] out_a, out_b;
    logic [3:0]  csx_a;
    logic [0:0]  csx_b;
    logic        sdo_a, sdo_b, sck_a, sck_b;
    logic        sel = 1'b0;
    logic [15:0] out_m;
    logic        sdo_m, sck_m;
    logic [7:0]  csx_m;

    int   n_chk = 0;
    int   n_fail = 0;
    logic exp_done;

    always #5 clk = ~clk;

    spi_master_px #(.WIDTH(8), .NCS(4), .DIV_INIT(0)) dut_a (
        .clk(clk), .reset(reset), .load(load_a), .addr(addr), .in(in), .out(out_a),
        .CSX(csx_a), .SDO(sdo_a), .SDI(SDI), .SCK(sck_a));

    spi_master_px #(.WIDTH(16), .NCS(1), .DIV_INIT(1)) dut_b (
        .clk(clk), .reset(reset), .load(load_b), .addr(addr), .in(in), .out(out_b),
        .CSX(csx_b), .SDO(sdo_b), .SDI(SDI), .SCK(sck_b));

    assign out_m = sel ? out_b : out_a;
    assign sdo_m = sel ? sdo_b : sdo_a;
    assign sck_m = sel ? sck_b : sck_a;
    assign csx_m = sel ? {7'd0, csx_b} : {4'd0, csx_a};

    typedef struct {
        logic [1:0]  mode;
        int          dv;
        logic [7:0]  tx;
        logic [7:0]  rx;
        logic        inj;
        int          exp_busy;
        logic [15:0] exp_rd;
    } vec_t;

    typedef struct {
        logic [15:0] ctrl;
        logic [3:0]  exp_csx;
    } csv_t;

    vec_t vt[6];
    csv_t ct[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bit the slave must present at edge e so the 2-flop synchroniser delivers bit n at its sample tick.
    function automatic logic sdi_val(input int e, input int w, input logic [1:0] m,
                                     input int dv, input logic [15:0] rx);
        for (int n = 0; n < w; n++) begin
            int s;
            s = m[0] ? 2 * n + 2 : 2 * n + 1;
            if ((dv + 1) * s - 2 >= e) return rx[w-1-n];
        end
        return 1'b0;
    endfunction

    task automatic wr(input logic a, input logic [15:0] d);
        @(negedge clk); #1;
        addr = a; in = d;
        if (sel) load_b = 1'b1; else load_a = 1'b1;
        @(negedge clk); #1;
        load_a = 1'b0; load_b = 1'b0; addr = 1'b1;
        #1;
    endtask

    task automatic run_xfer(input int w, input logic [1:0] m, input int dv,
                            input logic [15:0] tx, input logic [15:0] rx, input logic inj,
                            input int exp_busy, input logic [7:0] exp_csx);
        int          nb, rises, first_tog, e;
        logic        prev, csx_bad;
        logic [15:0] st;
        nb = 0; rises = 0; first_tog = -1; prev = m[1]; csx_bad = 1'b0;
        @(negedge clk); #1;
        load_a = 1'b0; load_b = 1'b0; addr = 1'b1;
        SDI = sdi_val(-1, w, m, dv, rx);
        @(negedge clk); #1;
        SDI = sdi_val(0, w, m, dv, rx);
        addr = 1'b0; in = tx;
        if (sel) load_b = 1'b1; else load_a = 1'b1;
        for (e = 1; e <= 400; e++) begin
            @(negedge clk); #1;
            load_a = 1'b0; load_b = 1'b0; addr = 1'b1;
            #1;
            st = out_m;
            if (!st[15]) break;
            nb++;
            for (int n = 0; n < w; n++) begin
                int s;
                s = m[0] ? 2 * n + 2 : 2 * n + 1;
                if (e == (dv + 1) * s) chk("sdo_bit", 32'(sdo_m), 32'(tx[w-1-n]));
            end
            if (first_tog < 0 && sck_m !== m[1]) first_tog = e - 1;
            if (!prev && sck_m) rises++;
            prev = sck_m;
            if (csx_m !== exp_csx) csx_bad = 1'b1;
            SDI = sdi_val(e, w, m, dv, rx);
            if (inj && e == 3) begin
                addr = 1'b0; in = 16'h00FF;
                if (sel) load_b = 1'b1; else load_a = 1'b1;
            end
            if (inj && e == 5) begin
                addr = 1'b1; in = 16'h0107;
                if (sel) load_b = 1'b1; else load_a = 1'b1;
            end
        end
        chk("busy_timeout", 32'(e <= 400), 32'd1);
        chk("busy_cycles", 32'(nb), 32'(exp_busy));
        chk("done_flag", 32'(st[14]), 32'd1);
        chk("ovr_flag", 32'(st[13]), 32'(inj));
        chk("sck_idle_after", 32'(sck_m), 32'(m[1]));
        chk("sck_rises", 32'(rises), 32'(w));
        chk("sck_first_toggle", 32'(first_tog), 32'(dv + 1));
        chk("csx_during_xfer", 32'(csx_bad), 32'd0);
        addr = 1'b0;
        #1;
        chk("rx_data", 32'(out_m), 32'(rx));
    endtask

    initial begin
        vt[0] = '{mode: 2'd0, dv: 0, tx: 8'hA5, rx: 8'h3C, inj: 1'b0, exp_busy: 17, exp_rd: 16'h003C};
        vt[1] = '{mode: 2'd1, dv: 3, tx: 8'hA5, rx: 8'h3C, inj: 1'b0, exp_busy: 68, exp_rd: 16'h003C};
        vt[2] = '{mode: 2'd2, dv: 3, tx: 8'hA5, rx: 8'h3C, inj: 1'b0, exp_busy: 68, exp_rd: 16'h003C};
        vt[3] = '{mode: 2'd3, dv: 3, tx: 8'hA5, rx: 8'h3C, inj: 1'b0, exp_busy: 68, exp_rd: 16'h003C};
        vt[4] = '{mode: 2'd0, dv: 2, tx: 8'h5A, rx: 8'hC3, inj: 1'b0, exp_busy: 51, exp_rd: 16'h00C3};
        vt[5] = '{mode: 2'd0, dv: 0, tx: 8'h96, rx: 8'h69, inj: 1'b1, exp_busy: 17, exp_rd: 16'h0069};
        ct[0] = '{ctrl: 16'h0024, exp_csx: 4'b1011};
        ct[1] = '{ctrl: 16'h0054, exp_csx: 4'b1111};
        ct[2] = '{ctrl: 16'h0020, exp_csx: 4'b1111};
        ct[3] = '{ctrl: 16'h0034, exp_csx: 4'b0111};

        // reset state of both instances
        repeat (3) @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; addr = 1'b1; #1;
            chk("rst_status", 32'(out_m), 32'h0000);
            addr = 1'b0; #1;
            chk("rst_data", 32'(out_m), 32'h0000);
            chk("rst_sck", 32'(sck_m), 32'd0);
            chk("rst_csx", 32'(csx_m), s ? 32'h01 : 32'h0F);
            chk("rst_sdo", 32'(sdo_m), 32'd0);
        end
        sel = 1'b0;
        reset = 1'b0;

        // asynchronous reset in the middle of a mode-3 transfer
        wr(1'b1, 16'h0007);
        chk("cpol_follow", 32'(sck_a), 32'd1);
        wr(1'b0, 16'h00A5);
        repeat (4) @(negedge clk);
        #1;
        addr = 1'b1; #1;
        chk("pre_reset_busy", 32'(out_a[15]), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_status", 32'(out_a), 32'h0000);
        chk("midrst_sck", 32'(sck_a), 32'd0);
        chk("midrst_csx", 32'(csx_a), 32'h0F);
        chk("midrst_sdo", 32'(sdo_a), 32'd0);
        @(negedge clk); #1;
        reset = 1'b0;

        exp_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr(1'b1, {vt[i].dv[7:0], 8'h04 | {6'd0, vt[i].mode}});
            chk("ctrl_status", 32'(out_a),
                32'({1'b0, exp_done, 1'b0, 6'd0, 3'd0, 1'b0, 1'b1, vt[i].mode}));
            chk("sck_idle_before", 32'(sck_a), 32'(vt[i].mode[1]));
            run_xfer(8, vt[i].mode, vt[i].dv, {8'd0, vt[i].tx}, vt[i].exp_rd,
                     vt[i].inj, vt[i].exp_busy, 8'h0E);
            exp_done = 1'b1;
        end

        // ignored writes left CTRL untouched but set ovr; an idle CTRL write clears it
        addr = 1'b1; #1;
        chk("ovr_status", 32'(out_a), 32'h6004);
        wr(1'b1, 16'h0004);
        chk("ovr_cleared", 32'(out_a), 32'h4004);

        for (int i = 0; i < 4; i++) begin
            wr(1'b1, ct[i].ctrl);
            chk("csx_decode", 32'(csx_a), 32'(ct[i].exp_csx));
        end

        // 16-bit instance, divider from DIV_INIT, SDI effectively tied high
        sel = 1'b1;
        addr = 1'b1; #1;
        chk("b_status_idle", 32'(out_b), 32'h0000);
        run_xfer(16, 2'd0, 1, 16'h8001, 16'hFFFF, 1'b0, 66, 8'h01);
        addr = 1'b0; in = 16'h1234; load_b = 1'b1;
        @(negedge clk); #1;
        load_b = 1'b0; addr = 1'b1; #1;
        chk("b2b_busy", 32'(out_b[15]), 32'd1);
        chk("b2b_done_clr", 32'(out_b[14]), 32'd0);
        chk("b2b_sdo_msb", 32'(sdo_b), 32'd0);
        begin
            int k;
            for (k = 0; k < 200; k++) begin
                @(negedge clk); #1;
                if (!out_b[15]) break;
            end
            chk("b2b_complete", 32'(k < 200), 32'd1);
            chk("b2b_busy_cycles", 32'(k + 1), 32'd66);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_px.md
Name: spi_master_px

Overview:
- Parametrised full-duplex SPI master for the Hack memory-mapped I/O space; successor to the fixed 8-bit, mode-0, single-CS SPI port.
- Adds configurable frame width, runtime clock divider, all four CPOL/CPHA modes, multiple active-low chip selects, and done/overrun status flags.
- Two 16-bit registers selected by addr: DATA (addr=0) and CTRL/STATUS (addr=1).

Parameters:
WIDTH, 8, frame length in bits, 1..16; TX data is in[WIDTH-1:0]
NCS, 1, number of chip-select lines, 1..8
DIV_INIT, 0, reset value of the CTRL divider field (half-period = DIV+1 clk cycles)

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
load  input  1  write strobe, sampled on the clk rising edge
addr  input  1  0 = DATA register, 1 = CTRL/STATUS register
in  input  16  write data
out  output  16  combinational read of the register selected by addr
CSX  output  NCS  chip selects, active low
SDO  output  1  serial data out (MOSI); always equals shift[WIDTH-1]
SDI  input  1  serial data in (MISO), asynchronous to clk
SCK  output  1  serial clock

Behaviour:
- Reset (asynchronous, immediate, also mid-transfer):
  - busy=done=ovr=0; shift=0 (SDO=0); CPHA=CPOL=cs_en=0; cs_sel=0; div=DIV_INIT
  - SCK=0; CSX all 1; SDI synchroniser cleared.
- CTRL write (load & addr=1 & !busy):
  - in[0]=CPHA, in[1]=CPOL, in[2]=cs_en, in[6:4]=cs_sel, in[15:8]=div.
  - Clears ovr. Takes effect on the next cycle.
- DATA write (load & addr=0 & !busy):
  - shift <= in[WIDTH-1:0]; busy <= 1; done <= 0; tick counter restarts.
- Any write while busy:
  - Ignored completely: no change to shift, CTRL or CSX.
  - Sets ovr (sticky).
- CSX: CSX[cs_sel]=0 when cs_en=1 and cs_sel<NCS; every other line is 1. cs_sel>=NCS drives all lines high. CSX is never changed by the transfer engine.
- SDI: passes through a 2-flop synchroniser. "Sampled SDI" means the synchroniser output at the sample tick.
- Timing:
  - Tick k (k=1..2W+1, W=WIDTH) occurs at the clk edge (div+1)*k cycles after the accepting load edge.
  - SCK = CPOL when idle. SCK toggles at ticks 1..2W; odd ticks are leading edges, even ticks are trailing edges.
- Sample and shift rules:
  - CPHA=0: sample at odd ticks 1,3,..,2W-1; shift at the following tick.
  - CPHA=1: sample at even ticks 2,4,..,2W; shift at the following tick.
  - Shift operation: shift <= {shift[W-2:0], sampled_bit}.
  - SDO holds the MSB from load until the first shift.
- End of transfer, at tick 2W+1:
  - Final shift (CPHA=1), busy <= 0, done <= 1.
  - SCK has already returned to CPOL after tick 2W.
  - Total busy time = (2W+1)*(div+1) cycles.
- Back-to-back: a DATA write in the first cycle with busy=0 is accepted.
- Read, addr=0: out = {(16-W)'d0, shift}. Reads partial data while busy.
- Read, addr=1: out = {busy, done, ovr, 6'd0, cs_sel[2:0], 1'b0, cs_en, CPOL, CPHA}.
- CTRL written while idle with a new CPOL: SCK follows on the next cycle.

Test Plan:
1. Reset, then read addr=1 -> out=16'h0000, SCK=0, CSX all 1, SDO=0. Assert reset mid-transfer -> same values immediately, no clock edge needed.
2. WIDTH=8, div=0, mode 0, cs_en=1, cs_sel=0.
   - Stimulus: DATA write 8'hA5, slave returns 8'h3C on SDI (held stable ≥2 cycles before each sample).
   - Response: SDO emits 1,0,1,0,0,1,0,1; SCK has 8 rising edges, first at cycle 1.
   - busy=1 for exactly 17 cycles; then addr=0 reads 16'h003C and done=1. CSX[0]=0 throughout.
3. Modes 1, 2, 3, div=3, same data as scenario 2:
   - SCK idles at CPOL; CPHA=1 samples on trailing edges.
   - busy lasts 68 cycles; read data 8'h3C in every mode.
4. DATA write, then during busy write DATA 8'hFF and CTRL 16'h0107:
   - Both writes are ignored; transfer completes with the original data.
   - Status reads ovr=1. A subsequent idle CTRL write clears ovr.
5. NCS=4: cs_sel=2, cs_en=1 -> CSX=4'b1011. cs_sel=5 -> CSX=4'b1111. cs_en=0 -> CSX=4'b1111.
6. WIDTH=16, div=1, DATA write 16'h8001 with SDI tied 1:
   - SDO MSB=1 first; busy for 66 cycles; read 16'hFFFF.
   - Immediate second write on the cycle busy falls -> accepted, done clears.
